// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
//   Shared types and helpers for the serial add/subtract unit.
//   - state_t  : controller states (IDLE, BUSY, DONE)
//   - MODE_ADD / MODE_SUB : encoding of the mode input
//   - clog2()  : ceiling log2, used to size the digit counter
// ---------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
//   Operand/result handshake bundle for serial_addsub.
//   Request side : in_valid, in_ready, mode, a, b, cin
//   Response side: out_valid, out_ready, result, cout, ovf, zero
//   master = producer of operands / consumer of results, slave = the unit.
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, mode, a, b, cin, out_ready,
      input  in_ready, out_valid, result, cout, ovf, zero
   );

   modport slave (
      input  in_valid, mode, a, b, cin, out_ready,
      output in_ready, out_valid, result, cout, ovf, zero
   );
endinterface

// File: rtl/addsub_digit.sv
// ---------------------------------------------------------------------------
// addsub_digit
//   Combinational DIGIT-bit ripple adder slice with subtract inversion.
//   x, y    : operand digits
//   ci      : incoming carry (invert=0) or incoming borrow (invert=1)
//   invert  : 1 in subtract mode; y and ci are complemented so the slice
//             computes x + ~y + ~borrow
//   s       : digit sum
//   co      : true carry out of the slice MSB (always in adder sense)
//   c_msb   : true carry into the slice MSB (for signed overflow)
// ---------------------------------------------------------------------------
module addsub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   input  logic             invert,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT-1:0] w_y;

   assign w_y = invert ? ~y : y;

   always_comb begin
      logic carry;
      // NOTE: every output gets a default before the loop so no path leaves
      // one unassigned, which would otherwise infer a latch.
      s     = '0;
      c_msb = 1'b0;
      // NOTE: blocking assignments here model the ripple: each iteration
      // must see the carry produced by the one before it.
      carry = invert ? ~ci : ci;
      for (int i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) begin
            c_msb = carry;
         end
         s[i]  = x[i] ^ w_y[i] ^ carry;
         carry = (x[i] & w_y[i]) | (carry & (x[i] ^ w_y[i]));
      end
      co = carry;
   end

endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle WIDTH-bit add/subtract unit, DIGIT bits per clock, behind a
//   valid/ready handshake on both sides. Latency WIDTH/DIGIT cycles from
//   accept to out_valid; one further cycle minimum for the out handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_if slave (operands, mode, cin in; result, cout,
//           ovf, zero out; valid/ready on both sides)
// ---------------------------------------------------------------------------
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_addsub_if.slave  bus
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? clog2(NDIG) : 1;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_mode;
   logic             r_cy;      // carry (add) or borrow (sub) into next digit
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic [DIGIT-1:0]       w_s;
   logic                   w_co;
   logic                   w_c_msb;
   logic                   w_sub;
   logic                   w_last;
   logic [WIDTH+DIGIT-1:0] w_res_cat;
   logic [WIDTH-1:0]       w_res_next;

   assign w_sub  = (r_mode == MODE_SUB);
   assign w_last = (r_cnt == CW'(NDIG - 1));

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x      (r_a[DIGIT-1:0]),
      .y      (r_b[DIGIT-1:0]),
      .ci     (r_cy),
      .invert (w_sub),
      .s      (w_s),
      .co     (w_co),
      .c_msb  (w_c_msb)
   );

   // New digit enters at the MSB end; after NDIG shifts digit 0 sits at bit 0.
   assign w_res_cat  = {w_s, r_res};
   assign w_res_next = w_res_cat[WIDTH+DIGIT-1:DIGIT];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are few and visible on the outputs,
         // so all of them are reset to give defined post-reset values.
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_mode  <= MODE_ADD;
         r_cy    <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_mode  <= (bus.mode == MODE_SUB) ? MODE_SUB : MODE_ADD;
                  r_cy    <= bus.cin;
                  r_cnt   <= '0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_a   <= r_a >> DIGIT;
               r_b   <= r_b >> DIGIT;
               r_res <= w_res_next;
               // Keep the running value in the mode's own sense (borrow in
               // sub), so after the last digit it already equals cout.
               r_cy  <= w_co ^ w_sub;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_cout  <= w_co ^ w_sub;
                  r_ovf   <= w_c_msb ^ w_co;
                  r_zero  <= (w_res_next == '0);
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.result    = r_res;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
   assign bus.zero      = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Drives three WIDTH=8 instances (DIGIT = 1, 2, 8) in lockstep from one set
//   of stimulus signals and compares each against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_addsub;
   import addsub_pkg::*;

   localparam int W     = 8;
   localparam int NINST = 3;

   logic clk;
   logic rst_n;

   logic         in_valid;
   logic         mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_ready;

   logic         ov  [NINST];
   logic         rdy [NINST];
   logic [W-1:0] res [NINST];
   logic         co  [NINST];
   logic         of  [NINST];
   logic         zr  [NINST];

   int digit_of [NINST] = '{1, 2, 8};
   int ndig_of  [NINST] = '{8, 4, 1};

   int n_checks = 0;
   int n_pass   = 0;

   generate
      for (genvar g = 0; g < NINST; g++) begin : g_inst
         localparam int DG = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
         serial_addsub_if #(.WIDTH(W)) bus ();
         serial_addsub #(.WIDTH(W), .DIGIT(DG)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
         );
         assign bus.in_valid  = in_valid;
         assign bus.mode      = mode;
         assign bus.a         = a;
         assign bus.b         = b;
         assign bus.cin       = cin;
         assign bus.out_ready = out_ready;
         assign ov[g]  = bus.out_valid;
         assign rdy[g] = bus.in_ready;
         assign res[g] = bus.result;
         assign co[g]  = bus.cout;
         assign of[g]  = bus.ovf;
         assign zr[g]  = bus.zero;
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic over the true values.
   // Returns {result[7:0], cout, ovf, zero}.
   function automatic logic [10:0] ref_op(input logic m, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic c);
      int ux, uy, sx, sy, u, s;
      logic [W-1:0] r;
      logic cf, vf;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (m == MODE_SUB) begin
         u  = ux - uy - int'(c);
         s  = sx - sy - int'(c);
         cf = (u < 0);
      end else begin
         u  = ux + uy + int'(c);
         s  = sx + sy + int'(c);
         cf = (u > 255);
      end
      r  = W'(u & 255);
      vf = (s < -128) || (s > 127);
      return {r, cf, vf, (r == 8'h00)};
   endfunction

   task automatic check_outs(input int i, input logic [10:0] exp, input string pfx);
      string t;
      t = $sformatf("%s_d%0d", pfx, digit_of[i]);
      check({t, "_result"}, 32'(res[i]), 32'(exp[10:3]));
      check({t, "_cout"},   32'(co[i]),  32'(exp[2]));
      check({t, "_ovf"},    32'(of[i]),  32'(exp[1]));
      check({t, "_zero"},   32'(zr[i]),  32'(exp[0]));
   endtask

   // One operation with out_ready held high; checks latency and outputs
   // of every instance when its out_valid first appears.
   task automatic run_op(input logic m, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic c, input string pfx);
      logic [10:0] exp;
      bit got [NINST];
      int cyc;
      exp = ref_op(m, x, y, c);
      @(negedge clk);
      mode      = m;
      a         = x;
      b         = y;
      cin       = c;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < NINST; i++) got[i] = 1'b0;
      @(posedge clk);
      cyc = 0;
      while (!(got[0] && got[1] && got[2]) && cyc < 20) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b0;
         for (int i = 0; i < NINST; i++) begin
            if (!got[i] && ov[i]) begin
               got[i] = 1'b1;
               check($sformatf("%s_d%0d_latency", pfx, digit_of[i]), 32'(cyc - 1), 32'(ndig_of[i]));
               check_outs(i, exp, pfx);
            end
         end
      end
      for (int i = 0; i < NINST; i++)
         if (!got[i]) check($sformatf("%s_d%0d_timeout", pfx, digit_of[i]), 32'(0), 32'(1));
   endtask

   initial begin
      logic [10:0] exp;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      mode      = MODE_ADD;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
         check($sformatf("rst_d%0d_in_ready", digit_of[i]), 32'(rdy[i]), 32'(1));
         check($sformatf("rst_d%0d_out_valid", digit_of[i]), 32'(ov[i]), 32'(0));
         check_outs(i, 11'h000, "rst");
      end
      rst_n = 1'b1;

      // Directed arithmetic corners
      run_op(MODE_SUB, 8'h05, 8'h03, 1'b0, "sub_basic");
      run_op(MODE_SUB, 8'h00, 8'h01, 1'b1, "sub_borrow");
      run_op(MODE_SUB, 8'h80, 8'h01, 1'b0, "sub_ovf");
      run_op(MODE_ADD, 8'hFF, 8'h01, 1'b0, "add_carry_zero");
      run_op(MODE_ADD, 8'h7F, 8'h00, 1'b1, "add_ovf");

      // Back-pressure in DONE with in_valid high and changing operands
      exp = ref_op(MODE_SUB, 8'h33, 8'h44, 1'b1);
      @(negedge clk);
      mode      = MODE_SUB;
      a         = 8'h33;
      b         = 8'h44;
      cin       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      repeat (9) begin
         @(negedge clk);
         a = 8'($urandom);
         b = 8'($urandom);
      end
      for (int i = 0; i < NINST; i++) check_outs(i, exp, "hold_entry");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a    = 8'($urandom);
         b    = 8'($urandom);
         mode = 1'($urandom);
         for (int i = 0; i < NINST; i++) begin
            check($sformatf("hold%0d_d%0d_out_valid", k, digit_of[i]), 32'(ov[i]), 32'(1));
            check($sformatf("hold%0d_d%0d_in_ready", k, digit_of[i]), 32'(rdy[i]), 32'(0));
            check_outs(i, exp, $sformatf("hold%0d", k));
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
         check($sformatf("release_d%0d_in_ready", digit_of[i]), 32'(rdy[i]), 32'(1));
         check($sformatf("release_d%0d_out_valid", digit_of[i]), 32'(ov[i]), 32'(0));
      end
      in_valid = 1'b0;
      run_op(MODE_ADD, 8'h12, 8'h34, 1'b1, "after_hold");

      // Reset mid-BUSY: leave ovf=1 on the outputs first
      run_op(MODE_ADD, 8'h7F, 8'h00, 1'b1, "pre_reset");
      @(negedge clk);
      mode     = MODE_SUB;
      a        = 8'h22;
      b        = 8'h11;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NINST; i++) begin
         check($sformatf("async_rst_d%0d_out_valid", digit_of[i]), 32'(ov[i]), 32'(0));
         check($sformatf("async_rst_d%0d_in_ready", digit_of[i]), 32'(rdy[i]), 32'(1));
         check_outs(i, 11'h000, "async_rst");
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(MODE_SUB, 8'h10, 8'h01, 1'b0, "post_reset");

      // Randomized operations against the reference
      for (int n = 0; n < 3000; n++) begin
         run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
